// File: rtl/store_trace_pkg.sv
// Shared types and defaults for the store-trace capture FIFO.
// STORE_TRACE_TIMESTAMP_EN adds a 32-bit timestamp field to each entry.
package store_trace_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int DROP_W_DEF = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
        logic [31:0] pc;
`ifdef STORE_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/store_trace_mem.sv
// Entry storage: DEPTH x trace_entry_t registers, one write port and one
// asynchronous read port. Contents are deliberately left unreset.
module store_trace_mem
    import store_trace_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output trace_entry_t rdata
);

    trace_entry_t mem [DEPTH];

    // Write the captured store into its slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/store_trace_fifo.sv
// Store-trace capture FIFO: snoops core stores (MemWrite && enable) into a
// first-word-fall-through queue drained over valid/ready. Full-FIFO stores
// are dropped and counted. Never back-pressures the core.
// Optional: STORE_TRACE_TIMESTAMP_EN stamps each entry with a cycle counter.
module store_trace_fifo
    import store_trace_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       Adr,
    input  logic [31:0]       WriteData,
    input  logic [31:0]       PC,
    input  logic              enable,
    input  logic              clear,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_adr,
    output logic [31:0]       trace_data,
    output logic [31:0]       trace_pc,
    output logic [31:0]       trace_ts,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_req, full, pop, push, drop;
    trace_entry_t  wentry, head;

    assign full     = (count == CW'(DEPTH));
    // Valid comes from registered occupancy only, never from trace_ready.
    assign trace_valid = (count != '0);
    assign push_req = MemWrite && enable;
    assign pop      = trace_valid && trace_ready;
    // A full FIFO still accepts a store when the head leaves the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter; only reset clears it, never `clear`.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 32'd1;
    end

    assign wentry   = '{adr: Adr, data: WriteData, pc: PC, ts: ts_cnt};
    assign trace_ts = trace_valid ? head.ts : '0;
`else
    assign wentry   = '{adr: Adr, data: WriteData, pc: PC};
    assign trace_ts = '0;
`endif

    store_trace_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Payload is masked while empty so it reads 0 out of reset and stays
    // stable, regardless of the unreset storage contents.
    assign trace_adr  = trace_valid ? head.adr  : '0;
    assign trace_data = trace_valid ? head.data : '0;
    assign trace_pc   = trace_valid ? head.pc   : '0;

    // Pointer, occupancy and drop bookkeeping; clear outranks push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

endmodule
